// File: rtl/dma_controller_if.sv
// Signal bundle between the DMA controller and its register window, source port and memory bus.
// The master modport is the controller side; the slave modport is the surrounding system.
interface dma_controller_if #(
  parameter int SRC_W  = 24,
  parameter int DATA_W = 16
);
  logic              reg_en;
  logic [1:0]        reg_sel;
  logic              reg_write;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic [SRC_W-1:0]  src_addr;
  logic              src_req;
  logic              src_ack;
  logic [DATA_W-1:0] src_data;
  logic              bus_req;
  logic              bus_grant;
  logic [DATA_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_write;
  logic              busy;
  logic              done;

  modport master (
    input  reg_en, reg_sel, reg_write, reg_wdata,
    output reg_rdata,
    output src_addr, src_req,
    input  src_ack, src_data,
    output bus_req,
    input  bus_grant,
    output dma_addr, dma_wdata, dma_write, busy, done
  );

  modport slave (
    output reg_en, reg_sel, reg_write, reg_wdata,
    input  reg_rdata,
    input  src_addr, src_req,
    output src_ack, src_data,
    input  bus_req,
    output bus_grant,
    input  dma_addr, dma_wdata, dma_write, busy, done
  );
endinterface

// File: rtl/dma_controller.sv
// Block-copy engine: reads words from the wide source port and writes them into the memory map
// while holding the CPU bus through a request/grant handshake.
module dma_controller #(
  parameter int SRC_W  = 24,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  dma_controller_if.master  dma
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_BUS = 3'd1,
    FETCH   = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int UPPER_W = SRC_W - DATA_W;

  localparam logic [1:0] SEL_SRC_L = 2'd0;
  localparam logic [1:0] SEL_SRC_U = 2'd1;
  localparam logic [1:0] SEL_DST   = 2'd2;
  localparam logic [1:0] SEL_AMT   = 2'd3;

  localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);
  localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);
  localparam logic [SRC_W-1:0]  SRC_ZERO  = SRC_W'(0);
  localparam logic [SRC_W-1:0]  SRC_ONE   = SRC_W'(1);

  state_t            state_r;
  logic [SRC_W-1:0]  src_r;
  logic [DATA_W-1:0] dst_r;
  logic [DATA_W-1:0] count_r;
  logic [DATA_W-1:0] data_r;
  logic              bus_req_r;
  logic              src_req_r;
  logic              in_write_r;
  logic              busy_r;
  logic              done_r;

  logic              reg_wr_s;
  logic [DATA_W-1:0] rdata_s;

  assign reg_wr_s = dma.reg_en & dma.reg_write;

  // Transfer sequencer: owns the address/count registers and every registered strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      src_r      <= SRC_ZERO;
      dst_r      <= DATA_ZERO;
      count_r    <= DATA_ZERO;
      data_r     <= DATA_ZERO;
      bus_req_r  <= 1'b0;
      src_req_r  <= 1'b0;
      in_write_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (reg_wr_s) begin
            case (dma.reg_sel)
              SEL_SRC_L: src_r[DATA_W-1:0]     <= dma.reg_wdata;
              SEL_SRC_U: src_r[SRC_W-1:DATA_W] <= dma.reg_wdata[UPPER_W-1:0];
              SEL_DST:   dst_r                 <= dma.reg_wdata;
              SEL_AMT: begin
                count_r <= dma.reg_wdata;
                // A zero count is simply stored; no bus request and no completion pulse.
                if (dma.reg_wdata != DATA_ZERO) begin
                  state_r   <= REQ_BUS;
                  bus_req_r <= 1'b1;
                  busy_r    <= 1'b1;
                end
              end
              default: state_r <= IDLE;
            endcase
          end
        end
        REQ_BUS: begin
          if (dma.bus_grant) begin
            state_r   <= FETCH;
            src_req_r <= 1'b1;
          end
        end
        FETCH: begin
          if (dma.src_ack) begin
            data_r     <= dma.src_data;
            src_req_r  <= 1'b0;
            in_write_r <= 1'b1;
            state_r    <= WRITE;
          end
        end
        WRITE: begin
          // The write only lands on a cycle where the bus is actually granted.
          if (dma.bus_grant) begin
            src_r      <= src_r + SRC_ONE;
            dst_r      <= dst_r + DATA_ONE;
            count_r    <= count_r - DATA_ONE;
            in_write_r <= 1'b0;
            if (count_r == DATA_ONE) begin
              state_r   <= DONE;
              bus_req_r <= 1'b0;
              done_r    <= 1'b1;
            end else begin
              state_r   <= FETCH;
              src_req_r <= 1'b1;
            end
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          bus_req_r  <= 1'b0;
          src_req_r  <= 1'b0;
          in_write_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  // Register readback mux for the CPU window.
  always_comb begin
    rdata_s = DATA_ZERO;
    if (dma.reg_en) begin
      case (dma.reg_sel)
        SEL_SRC_L: rdata_s = src_r[DATA_W-1:0];
        SEL_SRC_U: rdata_s = {{(DATA_W-UPPER_W){1'b0}}, src_r[SRC_W-1:DATA_W]};
        SEL_DST:   rdata_s = dst_r;
        SEL_AMT:   rdata_s = count_r;
        default:   rdata_s = DATA_ZERO;
      endcase
    end else begin
      rdata_s = DATA_ZERO;
    end
  end

  assign dma.reg_rdata = rdata_s;
  assign dma.src_addr  = src_r;
  assign dma.src_req   = src_req_r;
  assign dma.bus_req   = bus_req_r;
  assign dma.dma_addr  = dst_r;
  assign dma.dma_wdata = data_r;
  assign dma.dma_write = in_write_r & dma.bus_grant;
  assign dma.busy      = busy_r;
  assign dma.done      = done_r;

endmodule

// File: tb/tb_dma_controller.sv
// Scoreboard bench for dma_controller: stimulus queues expected memory writes and completions,
// an independent monitor pops and compares them whenever the DUT writes or signals done.
module tb_dma_controller;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dma_controller_if #(.SRC_W(24), .DATA_W(16)) dif ();

  dma_controller #(.SRC_W(24), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .dma (dif)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  exp_done_push = 0;
  int  done_cnt = 0;

  int  grant_delay = 0;
  int  ack_delay = 0;
  int  drop_req_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source ROM and bus arbiter model, updated just after each rising edge.
  initial begin : env
    int   gwait;
    int   ack_wait;
    int   drop_left;
    int   drop_taken;
    logic acked;
    gwait = 0; ack_wait = 0; drop_left = 0; drop_taken = 0;
    dif.bus_grant = 1'b0;
    dif.src_ack   = 1'b0;
    dif.src_data  = 16'h0000;
    forever begin
      @(posedge clk);
      acked = dif.src_ack;
      #1;
      if (!dif.src_req) begin
        dif.src_ack = 1'b0;
        ack_wait = 0;
      end else if (ack_wait < ack_delay) begin
        ack_wait++;
        dif.src_ack = 1'b0;
      end else begin
        dif.src_ack  = 1'b1;
        dif.src_data = dif.src_addr[15:0];
      end
      if (!dif.bus_req) begin
        dif.bus_grant = 1'b0;
        gwait = 0;
        drop_left = 0;
      end else if (gwait < grant_delay) begin
        gwait++;
        dif.bus_grant = 1'b0;
      end else if (drop_left > 0) begin
        drop_left--;
        dif.bus_grant = 1'b0;
      end else if (acked && (drop_taken < drop_req_cnt)) begin
        drop_taken++;
        drop_left = 1;
        dif.bus_grant = 1'b0;
      end else begin
        dif.bus_grant = 1'b1;
      end
    end
  end

  // Monitor: compares every write and completion against the scoreboard.
  initial begin : monitor
    logic prev_bus_req;
    wr_t  e;
    prev_bus_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (dif.dma_write) begin
          check("write_with_grant", dif.bus_grant, 1'b1);
          check("write_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("dma_addr", dif.dma_addr, e.addr);
            check("dma_wdata", dif.dma_wdata, e.data);
          end
        end
        if (dif.done) begin
          check("done_expected", done_cnt < exp_done_push, 1'b1);
          check("words_left_at_done", exp_q.size(), 0);
          check("bus_req_low_at_done", dif.bus_req, 1'b0);
          done_cnt++;
        end
        if (prev_bus_req && !dif.bus_req) check("bus_req_falls_with_done", dif.done, 1'b1);
      end
      prev_bus_req = dif.bus_req;
    end
  end

  task automatic reg_wr(input logic [1:0] sel, input logic [15:0] data);
    @(posedge clk);
    #1;
    dif.reg_en = 1'b1; dif.reg_sel = sel; dif.reg_write = 1'b1; dif.reg_wdata = data;
    @(posedge clk);
    #1;
    dif.reg_en = 1'b0; dif.reg_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] sel, input logic [15:0] exp, input string name);
    @(negedge clk);
    dif.reg_en = 1'b1; dif.reg_sel = sel;
    #1;
    check(name, dif.reg_rdata, exp);
    dif.reg_en = 1'b0;
  endtask

  task automatic start_xfer(input logic [23:0] s, input logic [15:0] d, input int n,
                            input bit expect_done);
    logic [23:0] sa;
    logic [15:0] da;
    reg_wr(2'd0, s[15:0]);
    reg_wr(2'd1, {8'h00, s[23:16]});
    reg_wr(2'd2, d);
    for (int i = 0; i < n; i++) begin
      sa = s + 24'(i);
      da = d + 16'(i);
      exp_q.push_back('{da, sa[15:0]});
    end
    if (expect_done) exp_done_push++;
    reg_wr(2'd3, 16'(n));
  endtask

  task automatic wait_done(input int max, output int cycles, output int gaps);
    bit got;
    got = 1'b0; cycles = 0; gaps = 0;
    while (!got && cycles < max) begin
      @(negedge clk);
      cycles++;
      if (dif.done) got = 1'b1;
      else if (!dif.bus_req) gaps++;
    end
    check("done_within_budget", got, 1'b1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int  cyc;
    int  gaps;
    bit  seen;
    dif.reg_en = 1'b0; dif.reg_sel = 2'd0; dif.reg_write = 1'b0; dif.reg_wdata = 16'h0000;
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    check("rst_bus_req", dif.bus_req, 1'b0);
    check("rst_src_req", dif.src_req, 1'b0);
    check("rst_dma_write", dif.dma_write, 1'b0);
    check("rst_busy", dif.busy, 1'b0);
    check("rst_done", dif.done, 1'b0);
    check("rst_src_addr", dif.src_addr, 24'h000000);
    check("rst_dma_addr", dif.dma_addr, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    reg_rd(2'd0, 16'h0000, "rst_rd_src_l");
    reg_rd(2'd3, 16'h0000, "rst_rd_amt");

    // Immediate grant/ack, 3 words.
    start_xfer(24'h021000, 16'h2400, 3, 1'b1);
    wait_done(40, cyc, gaps);
    check("done_latency_cycles", cyc, 8);
    check("busy_at_done", dif.busy, 1'b1);
    @(negedge clk);
    check("busy_after_done", dif.busy, 1'b0);
    reg_rd(2'd0, 16'h1003, "t1_rd_src_l");
    reg_rd(2'd1, 16'h0002, "t1_rd_src_u");
    reg_rd(2'd2, 16'h2403, "t1_rd_dst");
    reg_rd(2'd3, 16'h0000, "t1_rd_amt");

    // Zero count: nothing starts.
    reg_wr(2'd3, 16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dif.bus_req || dif.busy) seen = 1'b1;
    end
    check("amt0_no_bus_req", seen, 1'b0);

    // Address wrap in both source and destination.
    start_xfer(24'hFFFFFF, 16'hFFFF, 2, 1'b1);
    wait_done(40, cyc, gaps);
    reg_rd(2'd0, 16'h0001, "wrap_rd_src_l");
    reg_rd(2'd1, 16'h0000, "wrap_rd_src_u");
    reg_rd(2'd2, 16'h0001, "wrap_rd_dst");

    // Stalls: late grant, slow source, grant dropped in one write.
    grant_delay = 5; ack_delay = 3; drop_req_cnt = 1;
    start_xfer(24'h000500, 16'h3000, 3, 1'b1);
    wait_done(200, cyc, gaps);
    check("stall_bus_req_gaps", gaps, 0);
    reg_rd(2'd2, 16'h3003, "stall_rd_dst");
    grant_delay = 0;

    // Register writes while busy are ignored.
    start_xfer(24'h000040, 16'h5000, 3, 1'b1);
    repeat (3) @(posedge clk);
    check("mid_busy", dif.busy, 1'b1);
    reg_wr(2'd2, 16'h4400);
    reg_wr(2'd3, 16'h0009);
    wait_done(200, cyc, gaps);
    reg_rd(2'd2, 16'h5003, "mid_rd_dst");
    reg_rd(2'd0, 16'h0043, "mid_rd_src_l");
    reg_rd(2'd3, 16'h0000, "mid_rd_amt");

    // Readback in IDLE.
    reg_wr(2'd0, 16'hBEEF);
    reg_wr(2'd1, 16'h1234);
    reg_wr(2'd2, 16'hCAFE);
    reg_rd(2'd0, 16'hBEEF, "rb_src_l");
    reg_rd(2'd1, 16'h0034, "rb_src_u");
    reg_rd(2'd2, 16'hCAFE, "rb_dst");

    // Reset during the second fetch of a 4-word transfer.
    start_xfer(24'h000700, 16'h6000, 4, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dif.dma_write) seen = 1'b1;
    end
    check("rst_mid_first_write", seen, 1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rstmid_bus_req", dif.bus_req, 1'b0);
    check("rstmid_src_req", dif.src_req, 1'b0);
    check("rstmid_dma_write", dif.dma_write, 1'b0);
    check("rstmid_busy", dif.busy, 1'b0);
    check("rstmid_done", dif.done, 1'b0);
    check("rstmid_src_addr", dif.src_addr, 24'h000000);
    check("rstmid_dma_addr", dif.dma_addr, 16'h0000);
    check("rstmid_dma_wdata", dif.dma_wdata, 16'h0000);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ack_delay = 0;
    reg_rd(2'd0, 16'h0000, "post_rst_src_l");
    reg_rd(2'd2, 16'h0000, "post_rst_dst");
    exp_q.push_back('{16'h0000, 16'h0000});
    exp_done_push++;
    reg_wr(2'd3, 16'h0001);
    wait_done(40, cyc, gaps);
    check("post_rst_latency", cyc, 4);
    reg_rd(2'd0, 16'h0001, "post_rst_rd_src_l");
    reg_rd(2'd2, 16'h0001, "post_rst_rd_dst");

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("done_count", done_cnt, exp_done_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
